// File: rtl/ldst_sequencer.sv
// Load/store sequencer between execute and the single-port data memory.
// Define MISALIGNED_SPLIT_EN to split misaligned accesses into two beats instead of rejecting them.
module ldst_sequencer #(
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_is_store,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [3:0]              req_mask,
    input  logic                    req_unsigned,
    input  logic [4*BYTE_WIDTH-1:0] req_wdata,
    output logic                    mem_en,
    output logic [3:0]              mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [4*BYTE_WIDTH-1:0] mem_wdata,
    input  logic [4*BYTE_WIDTH-1:0] mem_rdata,
    input  logic                    mem_ack,
    output logic [3:0]              au_ldst_mask,
    output logic [1:0]              au_offset,
    output logic                    au_is_unsigned,
    output logic [4*BYTE_WIDTH-1:0] au_memory_out,
    input  logic [4*BYTE_WIDTH-1:0] au_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [4*BYTE_WIDTH-1:0] rsp_rdata,
    output logic                    rsp_error
);
    localparam int unsigned DW = 4 * BYTE_WIDTH;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t                state_q, state_d;
    logic                  req_ready_d, mem_en_d, rsp_valid_d, rsp_error_d;
    logic [3:0]            mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DW-1:0]         mem_wdata_d, rsp_rdata_d;

    logic                  is_store_q, uns_q;
    logic [3:0]            mask_q;
    logic [1:0]            off_q;
    logic                  accept, latch_req, finish, misaligned, reject;
    logic [1:0]            req_off;
    logic [3:0]            req_we_lo;
    logic [DW-1:0]         req_wd_lo;

    assign accept     = req_valid && req_ready;
    assign req_off    = req_addr[1:0];
    assign misaligned = (req_mask == 4'b0011 && req_off == 2'b11) ||
                        (req_mask == 4'b1111 && req_off != 2'b00);
    assign req_we_lo  = 4'(req_mask << req_off);
    assign req_wd_lo  = DW'(req_wdata << {req_off, 3'b000});

    assign au_ldst_mask   = mask_q;
    assign au_is_unsigned = uns_q;

`ifdef MISALIGNED_SPLIT_EN
    logic          split_q, word0_load;
    logic [3:0]    we_hi_q;
    logic [DW-1:0] wd_hi_q, word0_q;

    assign reject        = 1'b0;
    // Second beat carries the lanes that spilled past the first word.
    assign au_offset     = split_q ? 2'b00 : off_q;
    assign au_memory_out = split_q ? DW'({mem_rdata, word0_q} >> {off_q, 3'b000}) : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_q <= 1'b0;
            we_hi_q <= 4'b0000;
            wd_hi_q <= '0;
            word0_q <= '0;
        end else begin
            if (latch_req) begin
                split_q <= misaligned;
                we_hi_q <= 4'(({4'b0000, req_mask} << req_off) >> 4);
                wd_hi_q <= DW'(({{DW{1'b0}}, req_wdata} << {req_off, 3'b000}) >> DW);
            end
            if (word0_load) begin
                word0_q <= mem_rdata;
            end
        end
    end
`else
    assign reject        = misaligned;
    assign au_offset     = off_q;
    assign au_memory_out = mem_rdata;
`endif

    // Next-state and next-output logic for the registered memory/response outputs.
    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_error_d = rsp_error;
        latch_req   = 1'b0;
        finish      = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
        word0_load  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    latch_req = 1'b1;
                    if (req_mask == 4'b0000 || reject) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_error_d = reject;
                    end else begin
                        state_d     = ACC0;
                        mem_en_d    = 1'b1;
                        mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_we_d    = req_is_store ? req_we_lo : 4'b0000;
                        mem_wdata_d = req_wd_lo;
                    end
                end
            end
            ACC0: begin
                if (mem_ack) begin
`ifdef MISALIGNED_SPLIT_EN
                    if (split_q) begin
                        state_d     = ACC1;
                        word0_load  = 1'b1;
                        mem_addr_d  = mem_addr + ADDR_WIDTH'(4);
                        mem_we_d    = is_store_q ? we_hi_q : 4'b0000;
                        mem_wdata_d = wd_hi_q;
                    end else begin
                        finish = 1'b1;
                    end
`else
                    finish = 1'b1;
`endif
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            ACC1: begin
                if (mem_ack) begin
                    finish = 1'b1;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (finish) begin
            state_d     = RESP;
            mem_en_d    = 1'b0;
            mem_we_d    = 4'b0000;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = is_store_q ? '0 : au_out;
            rsp_error_d = 1'b0;
        end
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_ready  <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
            is_store_q <= 1'b0;
            uns_q      <= 1'b0;
            mask_q     <= 4'b0000;
            off_q      <= 2'b00;
        end else begin
            state_q   <= state_d;
            req_ready <= req_ready_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_error <= rsp_error_d;
            if (latch_req) begin
                is_store_q <= req_is_store;
                uns_q      <= req_unsigned;
                mask_q     <= req_mask;
                off_q      <= req_off;
            end
        end
    end
endmodule

// File: tb/tb_ldst_sequencer.sv
// Directed bench for ldst_sequencer: vector table plus reset corner cases.
// Expectations follow MISALIGNED_SPLIT_EN the same way the design does.
module tb_ldst_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_mask = '0;
    logic        mem_en, mem_ack = 1'b0;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  au_ldst_mask;
    logic [1:0]  au_offset;
    logic        au_is_unsigned;
    logic [31:0] au_memory_out, au_out, au_sh;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_error;
    logic [31:0] rsp_rdata;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        st;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic        uns;
        logic [31:0] wdata;
        int          dly;
        int          nb;
        logic [31:0] a0;
        logic [3:0]  we0;
        logic [31:0] wd0;
        logic [31:0] rd0;
        logic [31:0] a1;
        logic [3:0]  we1;
        logic [31:0] wd1;
        logic [31:0] rd1;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    ldst_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_mask(req_mask), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .au_ldst_mask(au_ldst_mask), .au_offset(au_offset), .au_is_unsigned(au_is_unsigned),
        .au_memory_out(au_memory_out), .au_out(au_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    // Behavioural alignment unit: select the addressed lanes, then extend.
    assign au_sh = au_memory_out >> {au_offset, 3'b000};
    always_comb begin
        case (au_ldst_mask)
            4'b0001: au_out = au_is_unsigned ? {24'h0, au_sh[7:0]}   : {{24{au_sh[7]}}, au_sh[7:0]};
            4'b0011: au_out = au_is_unsigned ? {16'h0, au_sh[15:0]}  : {{16{au_sh[15]}}, au_sh[15:0]};
            default: au_out = au_sh;
        endcase
    end

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL v%0d %s: got 0x%08h expected 0x%08h", idx, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [31:0] addr, input logic [3:0] mask,
                                input logic uns, input logic [31:0] wdata, input int dly, input int nb,
                                input logic [31:0] a0, input logic [3:0] we0, input logic [31:0] wd0,
                                input logic [31:0] rd0, input logic [31:0] a1, input logic [3:0] we1,
                                input logic [31:0] wd1, input logic [31:0] rd1,
                                input logic [31:0] exp_rd, input logic exp_err, input int hold);
        vec_t v;
        v.st = st; v.addr = addr; v.mask = mask; v.uns = uns; v.wdata = wdata;
        v.dly = dly; v.nb = nb;
        v.a0 = a0; v.we0 = we0; v.wd0 = wd0; v.rd0 = rd0;
        v.a1 = a1; v.we1 = we1; v.wd1 = wd1; v.rd1 = rd1;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.hold = hold;
        return v;
    endfunction

    task automatic run(input vec_t v, input int idx);
        int cyc;
        int beats;
        int wcnt;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = v.st; req_addr = v.addr; req_mask = v.mask;
        req_unsigned = v.uns; req_wdata = v.wdata;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk(idx, "req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        beats = 0; wcnt = 0; cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            mem_ack = 1'b0;
            if (mem_en) begin
                if (wcnt == v.dly) begin
                    if (beats == 0) begin
                        chk(idx, "beat0_addr", mem_addr, v.a0);
                        chk(idx, "beat0_we", 32'(mem_we), 32'(v.we0));
                        chk(idx, "beat0_wdata", mem_wdata, v.wd0);
                        mem_rdata = v.rd0;
                    end else begin
                        chk(idx, "beat1_addr", mem_addr, v.a1);
                        chk(idx, "beat1_we", 32'(mem_we), 32'(v.we1));
                        chk(idx, "beat1_wdata", mem_wdata, v.wd1);
                        mem_rdata = v.rd1;
                    end
                    mem_ack = 1'b1;
                    beats++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        mem_ack = 1'b0;
        chk(idx, "rsp_valid", 32'(rsp_valid), 32'd1);
        chk(idx, "beats", 32'(beats), 32'(v.nb));
        chk(idx, "latency", 32'(cyc), 32'(v.nb * (v.dly + 1)));
        chk(idx, "mem_en_idle", 32'(mem_en), 32'd0);
        chk(idx, "rsp_rdata", rsp_rdata, v.exp_rd);
        chk(idx, "rsp_error", 32'(rsp_error), 32'(v.exp_err));
        for (int i = 0; i < v.hold; i++) begin
            mem_ack = 1'b1;
            @(negedge clk);
            chk(idx, "hold_valid", 32'(rsp_valid), 32'd1);
            chk(idx, "hold_rdata", rsp_rdata, v.exp_rd);
            chk(idx, "hold_error", 32'(rsp_error), 32'(v.exp_err));
            chk(idx, "hold_mem_en", 32'(mem_en), 32'd0);
        end
        mem_ack = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk(idx, "rsp_done", 32'(rsp_valid), 32'd0);
        chk(idx, "ready_again", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk(0, 32'h100, 4'hF, 0, 0, 0, 1, 32'h100, 0, 0, 32'h44332211, 0, 0, 0, 0, 32'h44332211, 0, 0));
        vecs.push_back(mk(0, 32'h103, 4'h1, 0, 0, 0, 1, 32'h100, 0, 0, 32'h80FFFFFF, 0, 0, 0, 0, 32'hFFFFFF80, 0, 0));
        vecs.push_back(mk(0, 32'h103, 4'h1, 1, 0, 0, 1, 32'h100, 0, 0, 32'h80FFFFFF, 0, 0, 0, 0, 32'h00000080, 0, 0));
        vecs.push_back(mk(0, 32'h102, 4'h3, 0, 0, 2, 1, 32'h100, 0, 0, 32'hC3A51234, 0, 0, 0, 0, 32'hFFFFC3A5, 0, 1));
        vecs.push_back(mk(0, 32'h101, 4'h3, 1, 0, 1, 1, 32'h100, 0, 0, 32'h00ABCD00, 0, 0, 0, 0, 32'h0000ABCD, 0, 0));
        vecs.push_back(mk(1, 32'h200, 4'hF, 0, 32'hDEADBEEF, 1, 1, 32'h200, 4'hF, 32'hDEADBEEF, 32'h12345678, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h201, 4'h1, 0, 32'h000000AB, 0, 1, 32'h200, 4'h2, 32'h0000AB00, 32'h12345678, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h202, 4'h3, 0, 32'h00001234, 3, 1, 32'h200, 4'hC, 32'h12340000, 32'h12345678, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 32'h300, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h002, 4'h1, 0, 0, 0, 1, 32'h000, 0, 0, 32'h00FE0000, 0, 0, 0, 0, 32'hFFFFFFFE, 0, 0));
`ifdef MISALIGNED_SPLIT_EN
        vecs.push_back(mk(0, 32'h102, 4'hF, 0, 0, 0, 2, 32'h100, 0, 0, 32'h44332211, 32'h104, 0, 0, 32'h88776655, 32'h66554433, 0, 3));
        vecs.push_back(mk(0, 32'h101, 4'hF, 0, 0, 1, 2, 32'h100, 0, 0, 32'h44332211, 32'h104, 0, 0, 32'h88776655, 32'h55443322, 0, 0));
        vecs.push_back(mk(1, 32'h10F, 4'h3, 0, 32'h0000BEEF, 0, 2, 32'h10C, 4'h8, 32'hEF000000, 0, 32'h110, 4'h1, 32'h000000BE, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'hFFFFFFFF, 4'h3, 0, 0, 1, 2, 32'hFFFFFFFC, 0, 0, 32'h11223344, 32'h0, 0, 0, 32'h55667788, 32'hFFFF8811, 0, 0));
        vecs.push_back(mk(1, 32'h301, 4'hF, 0, 32'hAABBCCDD, 2, 2, 32'h300, 4'hE, 32'hBBCCDD00, 0, 32'h304, 4'h1, 32'h000000AA, 0, 0, 0, 0));
`else
        vecs.push_back(mk(0, 32'h102, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3));
        vecs.push_back(mk(0, 32'h101, 4'hF, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 32'h10F, 4'h3, 0, 32'h0000BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 32'hFFFFFFFF, 4'h3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 32'h301, 4'hF, 0, 32'hAABBCCDD, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
`endif

        // Reset values, then req_ready one cycle after release.
        #12;
        chk(-1, "rst_req_ready", 32'(req_ready), 32'd0);
        chk(-1, "rst_mem_en", 32'(mem_en), 32'd0);
        chk(-1, "rst_mem_we", 32'(mem_we), 32'd0);
        chk(-1, "rst_mem_addr", mem_addr, 32'd0);
        chk(-1, "rst_mem_wdata", mem_wdata, 32'd0);
        chk(-1, "rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk(-1, "rst_rsp_rdata", rsp_rdata, 32'd0);
        chk(-1, "rst_rsp_error", 32'(rsp_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk(-1, "ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk(-1, "ready_after_edge", 32'(req_ready), 32'd1);

        foreach (vecs[i]) run(vecs[i], i);

        // Asynchronous reset while a beat waits on its ack.
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h400; req_mask = 4'hF; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk(-2, "inflight_mem_en", 32'(mem_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk(-2, "arst_mem_en", 32'(mem_en), 32'd0);
        chk(-2, "arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk(-2, "arst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(-2, "post_rst_ready", 32'(req_ready), 32'd1);
        chk(-2, "post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk(-2, "post_rst_mem_en", 32'(mem_en), 32'd0);
        run(vecs[0], 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
